// File: rtl/block_sync_multilane_fsm.sv
// block_sync_multilane_fsm: per-lane sync-header lock machines with slip, post-slip blanking,
// selectable index recovery on loss of lock and an aggregate all-lanes-locked flag.
module block_sync_multilane_fsm #(
  parameter int N_LANES        = 20,
  parameter int NB_CODED_BLOCK = 66,
  parameter int NB_INDEX       = $clog2(NB_CODED_BLOCK),
  parameter int MAX_WINDOW     = 1024,
  parameter int NB_WINDOW_CNT  = $clog2(MAX_WINDOW) + 1,
  parameter int NB_INVALID_CNT = $clog2(MAX_WINDOW) + 1,
  parameter int NB_SLIP_WAIT   = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic [N_LANES-1:0]           i_signal_ok,
  input  logic [N_LANES-1:0]           i_sh_valid,
  input  logic [NB_WINDOW_CNT-1:0]     i_unlock_window,
  input  logic [NB_WINDOW_CNT-1:0]     i_lock_window,
  input  logic [NB_INVALID_CNT-1:0]    i_invalid_limit,
  input  logic [NB_SLIP_WAIT-1:0]      i_slip_wait,
  input  logic                         i_restart_mode,
  output logic [N_LANES*NB_INDEX-1:0]  o_block_index,
  output logic [N_LANES-1:0]           o_block_lock,
  output logic [N_LANES-1:0]           o_slip,
  output logic                         o_all_lock
);
  typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;
  localparam logic [NB_INDEX-1:0] IDX_MAX = NB_INDEX'(NB_CODED_BLOCK - 1);
  logic sample;
  logic [NB_WINDOW_CNT-1:0] unlock_lim, lock_lim;
  logic [NB_INVALID_CNT-1:0] inv_lim;
  assign sample     = i_enable && i_valid;
  assign unlock_lim = (i_unlock_window == '0) ? NB_WINDOW_CNT'(1) : i_unlock_window;
  assign lock_lim   = (i_lock_window == '0) ? NB_WINDOW_CNT'(1) : i_lock_window;
  assign inv_lim    = (i_invalid_limit == '0) ? NB_INVALID_CNT'(1) : i_invalid_limit;
  assign o_all_lock = &o_block_lock;
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    state_t state_q, state_d;
    logic [NB_INDEX-1:0] idx_q, idx_d, idx_inc;
    logic [NB_WINDOW_CNT-1:0] win_q, win_d, win_inc;
    logic [NB_INVALID_CNT-1:0] inv_q, inv_d, inv_inc;
    logic [NB_SLIP_WAIT-1:0] blank_q, blank_d;
    logic lock_q, lock_d, slip_q, slip_d;
    always_comb begin
      idx_inc = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      win_inc = (&win_q) ? win_q : win_q + 1'b1;
      inv_inc = (&inv_q || i_sh_valid[k]) ? inv_q : inv_q + 1'b1;
      state_d = state_q;
      idx_d   = idx_q;
      win_d   = win_q;
      inv_d   = inv_q;
      blank_d = blank_q;
      lock_d  = lock_q;
      slip_d  = 1'b0;
      if (sample) begin
        case (state_q)
          SEARCH: begin
            win_d = win_inc;
            if (!i_sh_valid[k]) begin
              idx_d   = idx_inc;
              slip_d  = 1'b1;
              win_d   = '0;
              inv_d   = '0;
              blank_d = i_slip_wait;
              state_d = (i_slip_wait == '0) ? SEARCH : SLIP_WAIT;
            end else if (win_inc >= unlock_lim) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
              win_d   = '0;
              inv_d   = '0;
            end
          end
          SLIP_WAIT: begin
            blank_d = blank_q - 1'b1;
            if (blank_q < NB_SLIP_WAIT'(2)) begin
              state_d = SEARCH;
              blank_d = '0;
              win_d   = '0;
              inv_d   = '0;
            end
          end
          default: begin
            win_d = win_inc;
            inv_d = inv_inc;
            // unlock takes priority over a window rollover on the same sample
            if (inv_inc >= inv_lim) begin
              lock_d  = 1'b0;
              slip_d  = 1'b1;
              idx_d   = i_restart_mode ? idx_inc : '0;
              win_d   = '0;
              inv_d   = '0;
              blank_d = i_slip_wait;
              state_d = (i_slip_wait == '0) ? SEARCH : SLIP_WAIT;
            end else if (win_inc >= lock_lim) begin
              win_d = '0;
              inv_d = '0;
            end
          end
        endcase
      end
    end
    always_ff @(posedge i_clock) begin
      if (i_reset || !i_signal_ok[k]) begin
        state_q <= SEARCH;
        idx_q   <= '0;
        win_q   <= '0;
        inv_q   <= '0;
        blank_q <= '0;
        lock_q  <= 1'b0;
        slip_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
        win_q   <= win_d;
        inv_q   <= inv_d;
        blank_q <= blank_d;
        lock_q  <= lock_d;
        slip_q  <= slip_d;
      end
    end
    assign o_block_index[k*NB_INDEX +: NB_INDEX] = idx_q;
    assign o_block_lock[k] = lock_q;
    assign o_slip[k]       = slip_q;
  end
endmodule

// File: tb/tb_block_sync_multilane_fsm.sv
// tb_block_sync_multilane_fsm: randomized and directed stimulus against a lane-level reference
// model; expected outputs are queued at each edge and checked by an independent monitor.
module tb_block_sync_multilane_fsm;
  localparam int N = 20, NBI = 7, NBW = 11, NBV = 11, NBS = 4, NCB = 66;
  logic i_clock = 1'b0;
  logic i_reset, i_enable, i_valid, i_restart_mode;
  logic [N-1:0] i_signal_ok, i_sh_valid;
  logic [NBW-1:0] i_unlock_window, i_lock_window;
  logic [NBV-1:0] i_invalid_limit;
  logic [NBS-1:0] i_slip_wait;
  logic [N*NBI-1:0] o_block_index;
  logic [N-1:0] o_block_lock, o_slip;
  logic o_all_lock;
  always #5 i_clock = ~i_clock;
  block_sync_multilane_fsm dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_signal_ok(i_signal_ok), .i_sh_valid(i_sh_valid), .i_unlock_window(i_unlock_window),
    .i_lock_window(i_lock_window), .i_invalid_limit(i_invalid_limit), .i_slip_wait(i_slip_wait),
    .i_restart_mode(i_restart_mode), .o_block_index(o_block_index), .o_block_lock(o_block_lock),
    .o_slip(o_slip), .o_all_lock(o_all_lock)
  );
  typedef struct packed {
    logic [N-1:0] lock;
    logic [N-1:0] slip;
    logic [N*NBI-1:0] idx;
    logic all;
  } exp_t;
  exp_t q[$];
  // lane mode: 0 hunting, 1 ignoring samples after a slip, 2 locked
  int m_mode[N], m_idx[N], m_win[N], m_bad[N], m_blank[N];
  bit m_lock[N], m_slip[N];
  int tests = 0, fails = 0, cycle = 0;
  task automatic model();
    exp_t e;
    int uw, lw, il, sw;
    uw = (i_unlock_window == 0) ? 1 : int'(i_unlock_window);
    lw = (i_lock_window == 0) ? 1 : int'(i_lock_window);
    il = (i_invalid_limit == 0) ? 1 : int'(i_invalid_limit);
    sw = int'(i_slip_wait);
    e = '0;
    for (int k = 0; k < N; k++) begin
      m_slip[k] = 0;
      if (i_reset || !i_signal_ok[k]) begin
        m_mode[k] = 0; m_idx[k] = 0; m_win[k] = 0; m_bad[k] = 0; m_blank[k] = 0; m_lock[k] = 0;
      end else if (i_enable && i_valid) begin
        if (m_mode[k] == 0) begin
          m_win[k] = (m_win[k] + 1 > 2047) ? 2047 : m_win[k] + 1;
          if (!i_sh_valid[k]) begin
            m_idx[k] = (m_idx[k] + 1) % NCB; m_slip[k] = 1; m_win[k] = 0;
            m_blank[k] = sw; m_mode[k] = (sw == 0) ? 0 : 1;
          end else if (m_win[k] >= uw) begin
            m_mode[k] = 2; m_lock[k] = 1; m_win[k] = 0; m_bad[k] = 0;
          end
        end else if (m_mode[k] == 1) begin
          m_blank[k]--;
          if (m_blank[k] == 0) begin m_mode[k] = 0; m_win[k] = 0; m_bad[k] = 0; end
        end else begin
          m_win[k] = (m_win[k] + 1 > 2047) ? 2047 : m_win[k] + 1;
          if (!i_sh_valid[k] && m_bad[k] < 2047) m_bad[k]++;
          if (m_bad[k] >= il) begin
            m_lock[k] = 0; m_slip[k] = 1;
            m_idx[k] = i_restart_mode ? (m_idx[k] + 1) % NCB : 0;
            m_win[k] = 0; m_bad[k] = 0; m_blank[k] = sw; m_mode[k] = (sw == 0) ? 0 : 1;
          end else if (m_win[k] >= lw) begin
            m_win[k] = 0; m_bad[k] = 0;
          end
        end
      end
      e.lock[k] = m_lock[k];
      e.slip[k] = m_slip[k];
      e.idx[k*NBI +: NBI] = NBI'(m_idx[k]);
    end
    e.all = &e.lock;
    q.push_back(e);
  endtask
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge i_clock);
      model();
      cycle++;
      #1;
    end
  endtask
  task automatic chk(string name, logic [N*NBI-1:0] got, logic [N*NBI-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, got, exp);
    end
  endtask
  always @(negedge i_clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("block_lock", (N*NBI)'(o_block_lock), (N*NBI)'(e.lock));
      chk("slip", (N*NBI)'(o_slip), (N*NBI)'(e.slip));
      chk("block_index", o_block_index, e.idx);
      chk("all_lock", (N*NBI)'(o_all_lock), (N*NBI)'(e.all));
    end
  end
  task automatic rand_sh(int err);
    for (int k = 0; k < N; k++) i_sh_valid[k] = (err == 0) ? 1'b1 : ($urandom_range(0, err - 1) != 0);
  endtask
  initial begin
    i_reset = 1; i_enable = 1; i_valid = 1; i_signal_ok = '1; i_sh_valid = '1;
    i_unlock_window = 64; i_lock_window = 1024; i_invalid_limit = 65; i_slip_wait = 2;
    i_restart_mode = 0;
    cyc(3);
    i_reset = 0;
    cyc(70);
    i_signal_ok[7] = 0;
    cyc(1);
    i_signal_ok[7] = 1;
    cyc(70);
    i_sh_valid = '1;
    i_sh_valid[3] = 0;
    i_reset = 1; cyc(1); i_reset = 0;
    for (int s = 1; s <= 140; s++) begin
      i_sh_valid = '1;
      if (s == 5 || s == 70) i_sh_valid[3] = 0;
      cyc(1);
    end
    cyc(70);
    i_reset = 1; cyc(1); i_reset = 0;
    cyc(64);
    for (int w = 0; w < 3; w++)
      for (int s = 0; s < 1024; s++) begin
        i_sh_valid = (s < 64) ? '0 : '1;
        if (s == 500) begin
          i_valid = 0; cyc(10); i_valid = 1;
        end
        cyc(1);
      end
    i_sh_valid = '0; i_restart_mode = 0;
    cyc(66);
    i_sh_valid = '1;
    cyc(70);
    i_sh_valid = '0; i_restart_mode = 1;
    cyc(66);
    i_reset = 1; cyc(1); i_reset = 0;
    i_unlock_window = 4; i_lock_window = 8; i_invalid_limit = 2; i_slip_wait = 1;
    i_sh_valid = '1;
    cyc(4);
    for (int s = 0; s < 8; s++) begin
      i_sh_valid = (s == 0 || s == 7) ? '0 : '1;
      cyc(1);
    end
    i_sh_valid = '1;
    cyc(3);
    i_sh_valid = '0; i_slip_wait = 0;
    cyc(150);
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        i_unlock_window = NBW'($urandom_range(1, 12));
        i_lock_window = NBW'($urandom_range(8, 40));
        i_invalid_limit = NBV'($urandom_range(1, 6));
        i_slip_wait = NBS'($urandom_range(0, 3));
        i_restart_mode = 1'($urandom_range(0, 1));
      end
      i_enable = ($urandom_range(0, 9) != 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_reset = ($urandom_range(0, 999) == 0);
      for (int k = 0; k < N; k++) i_signal_ok[k] = ($urandom_range(0, 299) != 0);
      rand_sh(6);
      cyc(1);
    end
    i_reset = 0; i_enable = 1; i_valid = 1; i_signal_ok = '1;
    i_unlock_window = 0; i_lock_window = 0; i_invalid_limit = 0; i_slip_wait = 0;
    for (int c = 0; c < 200; c++) begin
      rand_sh(3);
      cyc(1);
    end
    cyc(2);
    #10;
    chk("queue_drained", (N*NBI)'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
